// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit framer.
// CRC constants exist only when TX_FRAMER_CRC_EN is defined.
package tx_pkg;

    localparam int SEQ_W = 16;
    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        HDR,
        PAYLOAD
`ifdef TX_FRAMER_CRC_EN
        , TRAILER
`endif
    } state_t;

`ifdef TX_FRAMER_CRC_EN
    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    // Reflected CRC-32: bit 0 of byte 0 enters first, so walk the word LSB upward.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                               input logic [31:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 32; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/tx_framer_if.sv
// Input and output streams of the framer. The slave modport is the framer's view,
// the master modport is the view of the surrounding logic.
interface tx_framer_if;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_sof;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_sof, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_sof, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/stream_fifo.sv
// Show-ahead FIFO: rd_data presents the oldest entry whenever empty is low.
module stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/tx_framer.sv
// Wraps buffered payload words into sync/header/payload frames on a registered output.
// Define TX_FRAMER_CRC_EN to append a CRC-32 trailer word carrying tlast.
module tx_framer
    import tx_pkg::*;
#(
    parameter int unsigned C_FRAME_WORDS = 16,
    parameter logic [31:0] C_SYNC_WORD   = 32'hA5A5_5A5A,
    parameter int unsigned C_FIFO_DEPTH  = 16
) (
    input  logic        i_aclk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_clear_err,
    tx_framer_if.slave  bus,
    output logic [31:0] o_frame_count,
    output logic        o_sof_error
);
    localparam int LVL_W = $clog2(C_FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0] FRAME_LEN = LEN_W'(C_FRAME_WORDS);

    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [32:0]      fifo_dout;
    logic             push;
    logic             pop;
    logic             load;
    logic             produce;
    logic             avail_next;
    logic             last_payload;
    logic             last_out;
    logic             hs_last;
    logic [31:0]      word_out;
    logic [SEQ_W-1:0] seq;
    logic [LEN_W-1:0] word_idx;
    state_t           state;
    state_t           state_nxt;
    state_t           end_state;
`ifdef TX_FRAMER_CRC_EN
    logic [31:0]      crc;
`endif

    stream_fifo #(.WIDTH(33), .DEPTH(C_FIFO_DEPTH)) u_fifo (
        .clk     (i_aclk),
        .rst     (i_reset),
        .wr_en   (push),
        .wr_data ({bus.s_axis_sof, bus.s_axis_tdata}),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bus.s_axis_tready = !fifo_full && !i_reset;
    assign push         = bus.s_axis_tvalid && bus.s_axis_tready;
    assign load         = !bus.m_axis_tvalid || bus.m_axis_tready;
    assign pop          = (state == PAYLOAD) && load && !fifo_empty;
    assign last_payload = (word_idx == FRAME_LEN - 1'b1);
    assign hs_last      = bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast;

    // Chaining straight into SYNC at frame end avoids an idle bubble between frames.
    assign avail_next = push || (pop ? (fifo_level > LVL_W'(1)) : !fifo_empty);
    assign end_state  = (i_enable && avail_next) ? SYNC : IDLE;

    always_comb begin
        state_nxt = state;
        produce   = 1'b0;
        word_out  = '0;
        last_out  = 1'b0;
        case (state)
            IDLE: if (i_enable && !fifo_empty) state_nxt = SYNC;
            SYNC: if (load) begin
                produce   = 1'b1;
                word_out  = C_SYNC_WORD;
                state_nxt = HDR;
            end
            HDR: if (load) begin
                produce   = 1'b1;
                word_out  = {seq, FRAME_LEN};
                state_nxt = PAYLOAD;
            end
            PAYLOAD: if (pop) begin
                produce  = 1'b1;
                word_out = fifo_dout[31:0];
                if (last_payload) begin
`ifdef TX_FRAMER_CRC_EN
                    state_nxt = TRAILER;
`else
                    last_out  = 1'b1;
                    state_nxt = end_state;
`endif
                end
            end
`ifdef TX_FRAMER_CRC_EN
            TRAILER: if (load) begin
                produce   = 1'b1;
                word_out  = crc ^ CRC_XOROUT;
                last_out  = 1'b1;
                state_nxt = end_state;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Output register: reloads whenever the slot is free or being taken this cycle.
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            bus.m_axis_tvalid <= 1'b0;
            bus.m_axis_tdata  <= '0;
            bus.m_axis_tlast  <= 1'b0;
        end else if (load) begin
            bus.m_axis_tvalid <= produce;
            if (produce) begin
                bus.m_axis_tdata <= word_out;
                bus.m_axis_tlast <= last_out;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            word_idx      <= '0;
            seq           <= '0;
            o_frame_count <= '0;
            o_sof_error   <= 1'b0;
        end else begin
            if (pop) word_idx <= last_payload ? '0 : word_idx + 1'b1;
            if (hs_last) begin
                seq           <= seq + 1'b1;
                o_frame_count <= o_frame_count + 1'b1;
            end
            // A misplaced SOF wins over a same-cycle clear.
            if (pop && (word_idx != '0) && fifo_dout[32]) o_sof_error <= 1'b1;
            else if (i_clear_err)                          o_sof_error <= 1'b0;
        end
    end

`ifdef TX_FRAMER_CRC_EN
    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            crc <= CRC_INIT;
        end else if (produce) begin
            if (state == SYNC)         crc <= CRC_INIT;
            else if (state != TRAILER) crc <= crc32_word(crc, word_out);
        end
    end
`endif

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer (4-word frames); CRC trailer expected when TX_FRAMER_CRC_EN is defined.
module tb_tx_framer;
    localparam int FW = 4;
    localparam logic [31:0] SYNC_W = 32'hA5A5_5A5A;
`ifdef TX_FRAMER_CRC_EN
    localparam int FLEN = FW + 3;
`else
    localparam int FLEN = FW + 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [31:0] frame_count;
    logic        sof_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [32:0] got_q[$];
    int          got_cyc[$];
    logic [31:0] in_words[$];
    logic [32:0] exp_q[$];

    tx_framer_if bus();

    tx_framer #(
        .C_FRAME_WORDS (FW),
        .C_SYNC_WORD   (SYNC_W),
        .C_FIFO_DEPTH  (16)
    ) dut (
        .i_aclk        (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_clear_err   (clr),
        .bus           (bus),
        .o_frame_count (frame_count),
        .o_sof_error   (sof_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output word that will be accepted at the coming edge.
    always @(negedge clk) begin
        if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
            got_q.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
            got_cyc.push_back(cyc);
        end
    end

`ifdef TX_FRAMER_CRC_EN
    function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [31:0] w);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 4; b++) begin
            c = c ^ {24'h0, w[8*b +: 8]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction
`endif

    // Reference frames from the list of words fed in, seq starting at first_seq.
    task automatic build_expected(input int first_seq);
        logic [31:0] hdr;
        logic [31:0] w;
`ifdef TX_FRAMER_CRC_EN
        logic [31:0] c;
`endif
        exp_q.delete();
        for (int f = 0; f < in_words.size() / FW; f++) begin
            hdr = {16'(first_seq + f), 16'(FW)};
            exp_q.push_back({1'b0, SYNC_W});
            exp_q.push_back({1'b0, hdr});
`ifdef TX_FRAMER_CRC_EN
            c = crc_ref(32'hFFFF_FFFF, hdr);
`endif
            for (int i = 0; i < FW; i++) begin
                w = in_words[f*FW + i];
`ifdef TX_FRAMER_CRC_EN
                c = crc_ref(c, w);
                exp_q.push_back({1'b0, w});
`else
                exp_q.push_back({(i == FW-1), w});
`endif
            end
`ifdef TX_FRAMER_CRC_EN
            exp_q.push_back({1'b1, c ^ 32'hFFFF_FFFF});
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_sof    = 1'b0;
        bus.s_axis_tdata  = '0;
        repeat (3) tick();
        rst = 1'b0;
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic send_word(input logic sof, input logic [31:0] data);
        bit acc;
        acc = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_sof    = sof;
        bus.s_axis_tdata  = data;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            tick();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h never accepted", data);
        end
    endtask

    task automatic wait_outputs(input int n);
        for (int t = 0; t < 3000 && got_q.size() < n; t++) @(negedge clk);
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got %0d words, required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b, required 0", bus.s_axis_tready); end
        if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", bus.m_axis_tvalid); end
        if (bus.m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h, required 0", bus.m_axis_tdata); end
        if (bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b, required 0", bus.m_axis_tlast); end
        if (frame_count !== 32'h0) begin errors++; $display("FAIL rst_count: got %h, required 0", frame_count); end
        if (sof_err !== 1'b0) begin errors++; $display("FAIL rst_sof_err: got %b, required 0", sof_err); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b, required 1", bus.s_axis_tready); end
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1;
        bus.m_axis_tready = 1'b1;
        in_words.delete();
        for (int i = 1; i <= FW; i++) in_words.push_back(32'(i));
        build_expected(0);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_sof    = 1'b1;
        bus.s_axis_tdata  = 32'd1;
        fork
            begin
                for (int i = 2; i <= FW; i++) begin
                    tick();
                    bus.s_axis_sof   = 1'b0;
                    bus.s_axis_tdata = 32'(i);
                end
                tick();
                bus.s_axis_tvalid = 1'b0;
            end
            begin
                @(posedge clk);
                for (int c = 0; c <= FLEN + 1; c++) begin
                    @(negedge clk);
                    checks++;
                    if (c < 2) begin
                        if (bus.m_axis_tvalid !== 1'b0) begin
                            errors++;
                            $display("FAIL basic_latency c=%0d: got valid %b, required 0", c, bus.m_axis_tvalid);
                        end
                    end else if (bus.m_axis_tvalid !== 1'b1 ||
                                 {bus.m_axis_tlast, bus.m_axis_tdata} !== exp_q[c-2]) begin
                        errors++;
                        $display("FAIL basic_word c=%0d: got valid %b word %h, required valid 1 word %h",
                                 c, bus.m_axis_tvalid, {bus.m_axis_tlast, bus.m_axis_tdata}, exp_q[c-2]);
                    end
                end
                @(negedge clk);
                checks += 3;
                if (frame_count !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d, required 1", frame_count); end
                if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b, required 0", bus.m_axis_tvalid); end
                if (sof_err !== 1'b0) begin errors++; $display("FAIL basic_sof_err: got %b, required 0", sof_err); end
            end
        join
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        bus.m_axis_tready = 1'b1;
        in_words.delete();
        for (int i = 0; i < 2*FW; i++) in_words.push_back($urandom);
        build_expected(0);
        for (int i = 0; i < 2*FW; i++) send_word(i % FW == 0, in_words[i]);
        bus.s_axis_tvalid = 1'b0;
        wait_outputs(2*FLEN);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_len: got %0d words, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
            checks += 2;
            if (got_q[FLEN+1][31:0] !== 32'h0001_0004) begin
                errors++;
                $display("FAIL b2b_hdr2: got %h, required 00010004", got_q[FLEN+1][31:0]);
            end
            if (got_cyc[2*FLEN-1] - got_cyc[0] != 2*FLEN - 1) begin
                errors++;
                $display("FAIL b2b_gap: got span %0d cycles, required %0d", got_cyc[2*FLEN-1] - got_cyc[0], 2*FLEN - 1);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        en = 1'b0;
        bus.m_axis_tready = 1'b0;
        in_words.delete();
        for (int i = 0; i < 8*FW; i++) in_words.push_back($urandom);
        build_expected(0);
        for (int i = 0; i < 16; i++) send_word(i % FW == 0, in_words[i]);
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL stall_full_tready: got %b, required 0", bus.s_axis_tready); end
        if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL stall_disabled_valid: got %b, required 0", bus.m_axis_tvalid); end
        tick();
        en = 1'b1;
        fork
            begin
                for (int i = 16; i < 8*FW; i++) send_word(i % FW == 0, in_words[i]);
                bus.s_axis_tvalid = 1'b0;
            end
            begin
                bit          sp;
                logic [32:0] sw;
                sp = 1'b0;
                sw = '0;
                for (int t = 0; t < 4000 && got_q.size() < 8*FLEN; t++) begin
                    @(negedge clk);
                    if (sp) begin
                        checks++;
                        if (bus.m_axis_tvalid !== 1'b1 || {bus.m_axis_tlast, bus.m_axis_tdata} !== sw) begin
                            errors++;
                            $display("FAIL stall_stable: got valid %b word %h, required valid 1 word %h",
                                     bus.m_axis_tvalid, {bus.m_axis_tlast, bus.m_axis_tdata}, sw);
                        end
                    end
                    sp = bus.m_axis_tvalid && !bus.m_axis_tready;
                    sw = {bus.m_axis_tlast, bus.m_axis_tdata};
                    tick();
                    bus.m_axis_tready = 1'($urandom_range(0, 1));
                end
                bus.m_axis_tready = 1'b1;
            end
        join
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_len: got %0d words, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_sof_error();
        do_reset();
        en = 1'b1;
        bus.m_axis_tready = 1'b1;
        in_words.delete();
        for (int i = 0; i < FW; i++) in_words.push_back($urandom);
        build_expected(0);
        for (int i = 0; i < FW; i++) send_word(i == 0 || i == 2, in_words[i]);
        bus.s_axis_tvalid = 1'b0;
        wait_outputs(FLEN);
        repeat (3) @(negedge clk);
        checks += 3;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sof_len: got %0d words, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sof_word %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
        end
        if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_flag_set: got %b, required 1", sof_err); end
        if (frame_count !== 32'd1) begin errors++; $display("FAIL sof_count: got %0d, required 1", frame_count); end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (sof_err !== 1'b0) begin errors++; $display("FAIL sof_flag_clear: got %b, required 0", sof_err); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) send_word(i == 0, $urandom);
        bus.s_axis_tvalid = 1'b0;
        wait_outputs(2);
        tick();
        bus.m_axis_tready = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (bus.m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b, required 1", bus.m_axis_tvalid); end
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", bus.m_axis_tvalid); end
        if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b, required 0", bus.s_axis_tready); end
        tick();
        rst = 1'b0;
        got_q.delete();
        got_cyc.delete();
        bus.m_axis_tready = 1'b1;
        in_words.delete();
        for (int i = 0; i < FW; i++) in_words.push_back($urandom);
        build_expected(0);
        for (int i = 0; i < FW; i++) send_word(i == 0, in_words[i]);
        bus.s_axis_tvalid = 1'b0;
        wait_outputs(FLEN);
        repeat (2) @(negedge clk);
        checks += 2;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL mid_len: got %0d words, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_word %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
        end
        if (frame_count !== 32'd1) begin errors++; $display("FAIL mid_count: got %0d, required 1", frame_count); end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_sof    = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_sof_error();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
